vga_timing_rx: RTL and testbench
================================

Name: vga_timing_rx

Overview:
- Sink-side counterpart of the VGA timing generator: consumes the h/v/bn sync triple and recovers pixel coordinates.
- Measures line and frame timing, checks it against the expected mode and reports lock/error.
- Used to self-check the generator on the board.
- Also lets downstream pixel logic run from sync signals only, without access to the generator's internal row/col.

Parameters:
- H_TOTAL, 800, clocks per line (h falling edge to next h falling edge)
- V_TOTAL, 525, lines per frame (h falling edges between v falling edges)
- H_ACTIVE, 640, clocks per line with bn=1
- V_ACTIVE, 480, lines per frame containing bn=1
- LOCK_FRAMES, 2, consecutive good frames needed to assert locked (1..15)

Ports:
- clk  in  1  pixel clock (same clock that drives the generator)
- reset  in  1  asynchronous, active-low; clears all state
- h  in  1  horizontal sync, active-low
- v  in  1  vertical sync, active-low
- bn  in  1  display enable; 1 = visible pixel, 0 = blanking
- col  out  10  recovered column of current visible pixel
- row  out  10  recovered row of current visible pixel
- de  out  1  recovered display enable, aligned with col/row
- sof  out  1  one-cycle pulse on first visible pixel of a frame (row 0, col 0)
- locked  out  1  timing matches parameters for LOCK_FRAMES frames
- err  out  1  one-cycle pulse on a timing violation while locked
- line_len  out  11  clocks in last completed line
- frame_lines  out  11  lines in last completed frame

Behaviour:
- Reset (async, reset=0): all outputs 0, all counters 0, FSM in SEARCH, frame_valid=0. Reset mid-frame discards all measurement state.
- Input pipeline:
  - h, v and bn are registered twice (d1, d2).
  - Edge detection uses d1 vs d2: fall = d2 & ~d1, rise = ~d2 & d1.
  - All outputs are registered, so de/col/row lag the bn pin by exactly 2 clocks.
- Column recovery:
  - bn rise: col<=0, de<=1.
  - bn steady high: col<=col+1, saturating at 1023.
  - bn fall: de<=0, col holds.
- Row recovery:
  - v fall: row<=0.
  - bn fall: row<=row+1, saturating at 1023.
  - v fall coinciding with bn fall: v wins (row<=0).
- sof: 1 for one cycle when bn rises and no bn fall has occurred since the last v fall.
- Line measurement:
  - hcnt (11 bit, saturating at 2047) counts clocks.
  - h fall: line_len<=hcnt+1, hcnt<=0.
  - A line is good iff line_len==H_TOTAL and the visible clock count of that line (from col at bn fall, +1) ==H_ACTIVE.
  - A line with no bn=1 has visible count 0 and is exempt from the H_ACTIVE check.
- Frame measurement:
  - vlines counts h falls; alines counts bn falls.
  - v fall: frame_lines<=vlines, vlines<=0, alines<=0, frame_valid<=1.
  - A frame is good iff frame_valid was already 1 at this v fall, every line in it was good, vlines==V_TOTAL and alines==V_ACTIVE.
  - The first frame after reset is partial, therefore not good, and never raises err.
- Lock FSM (good_cnt 4 bit):
  - SEARCH: v fall with good frame -> good_cnt<=1, go VERIFY (or LOCKED if LOCK_FRAMES==1).
  - VERIFY: v fall with good frame -> good_cnt+1; on reaching LOCK_FRAMES go LOCKED. Any bad line or bad frame -> good_cnt<=0, go SEARCH.
  - LOCKED: locked=1. Bad line (at its h fall) or bad frame (at v fall) -> err=1 for one cycle, locked<=0, good_cnt<=0, go SEARCH.
  - locked is registered: it rises the cycle after the qualifying v fall and falls in the same cycle err pulses.
- A bad line and a v fall in the same cycle produce a single err pulse.
- Sync stuck inactive: hcnt saturates at 2047 and no edges occur. When the next edge finally arrives it reports 2047 and the line/frame is bad.

Test Plan:
- Nominal 640x480 stream from the generator after reset release: frame_lines=525, line_len=800. locked rises 1 clock after the 3rd v fall, with no err.
- Coordinates: at the first visible pixel, de=1, col=0, row=0 and sof=1 exactly 2 clocks after bn rises. The final visible pixel shows col=639, row=479. de=0 during blanking.
- While locked, stretch one line to 801 clocks: at that h fall (2-clock lag) err pulses once, locked=0, line_len=801. locked returns after 2 further good frames.
- Frame of 524 lines: frame_lines=524, locked never asserts. Restoring 525 locks after 2 good frames.
- Hold bn=1 for 1100 clocks: col saturates at 1023 and does not wrap. That line is bad, and the line after it restarts at col 0.
- Assert reset mid-frame while locked: all outputs 0 immediately. After release, the first frame is ignored and lock is re-acquired on the 3rd v fall.

Source files
------------

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates from an h/v/bn sync triple,
// measures line and frame timing against the expected mode and reports
// lock status and timing violations.
module vga_timing_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h,
    input  logic        v,
    input  logic        bn,
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic        de,
    output logic        sof,
    output logic        locked,
    output logic        err,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines
);

    localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
    localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);
    localparam logic [3:0]  LOCK_N     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] x);
        return (x == 11'h7FF) ? x : x + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    logic h_d1, h_d2, v_d1, v_d2, bn_d1, bn_d2;
    logic h_fall, v_fall, bn_rise, bn_fall;

    logic [10:0] hcnt_reg;
    logic [10:0] vis_reg;
    logic [10:0] vlines_reg;
    logic [10:0] alines_reg;
    logic        lines_ok_reg;
    logic        frame_valid_reg;
    logic        fell_reg;

    logic [10:0] line_len_now;
    logic [10:0] vis_now;
    logic [10:0] vlines_now;
    logic [10:0] alines_now;
    logic        line_good;
    logic        line_bad;
    logic        lines_ok_now;
    logic        frame_good;
    logic        frame_ok_evt;
    logic        frame_bad;

    state_t      state_reg, state_next;
    logic [3:0]  good_cnt_reg, good_cnt_next;
    logic        locked_next;
    logic        err_next;

    // Two-stage capture of the sync inputs; edges are taken between the stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_d1  <= 1'b0;
            h_d2  <= 1'b0;
            v_d1  <= 1'b0;
            v_d2  <= 1'b0;
            bn_d1 <= 1'b0;
            bn_d2 <= 1'b0;
        end else begin
            h_d1  <= h;
            h_d2  <= h_d1;
            v_d1  <= v;
            v_d2  <= v_d1;
            bn_d1 <= bn;
            bn_d2 <= bn_d1;
        end
    end

    assign h_fall  = h_d2 & ~h_d1;
    assign v_fall  = v_d2 & ~v_d1;
    assign bn_rise = ~bn_d2 & bn_d1;
    assign bn_fall = bn_d2 & ~bn_d1;

    // A bn fall or h fall landing in the same cycle as the closing edge
    // still belongs to the line/frame being closed.
    assign line_len_now = sat_inc11(hcnt_reg);
    assign vis_now      = bn_fall ? ({1'b0, col} + 11'd1) : vis_reg;
    assign line_good    = (line_len_now == H_TOTAL_W) &&
                          ((vis_now == 11'd0) || (vis_now == H_ACTIVE_W));
    assign line_bad     = h_fall & ~line_good;
    assign vlines_now   = h_fall  ? sat_inc11(vlines_reg) : vlines_reg;
    assign alines_now   = bn_fall ? sat_inc11(alines_reg) : alines_reg;
    assign lines_ok_now = lines_ok_reg & ~line_bad;
    assign frame_good   = frame_valid_reg & lines_ok_now &
                          (vlines_now == V_TOTAL_W) & (alines_now == V_ACTIVE_W);
    assign frame_ok_evt = v_fall & frame_good;
    assign frame_bad    = v_fall & ~frame_good;

    // Coordinate recovery: column from bn, row from bn falls since v fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col      <= 10'd0;
            row      <= 10'd0;
            de       <= 1'b0;
            sof      <= 1'b0;
            fell_reg <= 1'b0;
        end else begin
            if (bn_rise) begin
                col <= 10'd0;
                de  <= 1'b1;
            end else if (bn_d2 && bn_d1) begin
                col <= sat_inc10(col);
            end else if (bn_fall) begin
                de  <= 1'b0;
            end

            if (v_fall) begin
                row <= 10'd0;
            end else if (bn_fall) begin
                row <= sat_inc10(row);
            end

            if (v_fall) begin
                fell_reg <= 1'b0;
            end else if (bn_fall) begin
                fell_reg <= 1'b1;
            end

            sof <= bn_rise & (v_fall | ~fell_reg);
        end
    end

    // Line and frame measurement counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_reg        <= 11'd0;
            vis_reg         <= 11'd0;
            vlines_reg      <= 11'd0;
            alines_reg      <= 11'd0;
            lines_ok_reg    <= 1'b0;
            frame_valid_reg <= 1'b0;
            line_len        <= 11'd0;
            frame_lines     <= 11'd0;
        end else begin
            if (h_fall) begin
                hcnt_reg <= 11'd0;
                line_len <= line_len_now;
                vis_reg  <= 11'd0;
            end else begin
                hcnt_reg <= sat_inc11(hcnt_reg);
                vis_reg  <= vis_now;
            end

            if (v_fall) begin
                frame_lines     <= vlines_now;
                vlines_reg      <= 11'd0;
                alines_reg      <= 11'd0;
                lines_ok_reg    <= 1'b1;
                frame_valid_reg <= 1'b1;
            end else begin
                vlines_reg   <= vlines_now;
                alines_reg   <= alines_now;
                lines_ok_reg <= lines_ok_now;
            end
        end
    end

    // Lock FSM state and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= SEARCH;
            good_cnt_reg <= 4'd0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
            locked       <= locked_next;
            err          <= err_next;
        end
    end

    // Lock FSM next state: count consecutive good frames, drop on any violation.
    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        err_next      = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (frame_ok_evt) begin
                    good_cnt_next = 4'd1;
                    state_next    = (LOCK_N <= 4'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (line_bad || frame_bad) begin
                    good_cnt_next = 4'd0;
                    state_next    = SEARCH;
                end else if (frame_ok_evt) begin
                    good_cnt_next = good_cnt_reg + 4'd1;
                    if ((good_cnt_reg + 4'd1) >= LOCK_N) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad) begin
                    err_next      = 1'b1;
                    good_cnt_next = 4'd0;
                    state_next    = SEARCH;
                end
            end
            default: begin
                good_cnt_next = 4'd0;
                state_next    = SEARCH;
            end
        endcase
        locked_next = (state_next == LOCKED);
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: a small-mode sync generator drives the DUT, an
// event/timestamp model predicts every output each cycle, and literal
// checks pin the key scenarios.
module tb_vga_timing_rx;

    localparam int HT = 40;
    localparam int VT = 12;
    localparam int HA = 24;
    localparam int VA = 8;
    localparam int LF = 2;
    localparam int HS = 28;   // h sync low at columns HS..HS+3
    localparam int VS = 9;    // v sync low on rows VS, VS+1

    logic        clk = 1'b0;
    logic        reset;
    logic        h, v, bn;
    logic [9:0]  col, row;
    logic        de, sof, locked, err;
    logic [10:0] line_len, frame_lines;

    int tests_run = 0;
    int tests_failed = 0;

    vga_timing_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .h(h), .v(v), .bn(bn),
        .col(col), .row(row), .de(de), .sof(sof), .locked(locked), .err(err),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- behavioural model (timestamps and event counts) -------
    int t = 0, t_rise = 0, t_hlast = 0;
    int s1_h = 0, s1_v = 0, s1_bn = 0, s2_h = 0, s2_v = 0, s2_bn = 0;
    int vis_line = 0, hf_cnt = 0, bf_cnt = 0, lines_good = 0, frame_valid = 0, streak = 0;
    int e_col = 0, e_row = 0, e_de = 0, e_sof = 0, e_locked = 0, e_err = 0;
    int e_line_len = 0, e_frame_lines = 0;

    task automatic model_clear();
        t = 0; t_rise = 0; t_hlast = 0;
        s1_h = 0; s1_v = 0; s1_bn = 0; s2_h = 0; s2_v = 0; s2_bn = 0;
        vis_line = 0; hf_cnt = 0; bf_cnt = 0; lines_good = 0; frame_valid = 0; streak = 0;
        e_col = 0; e_row = 0; e_de = 0; e_sof = 0; e_locked = 0; e_err = 0;
        e_line_len = 0; e_frame_lines = 0;
    endtask

    task automatic model_step();
        bit hf, vf, br, bf, bad_line, bad_frame, good_frame, was_locked;
        int len;
        t++;
        // events seen on the delayed copy of the pins (two-clock lag)
        hf = (s2_h == 1) && (s1_h == 0);
        vf = (s2_v == 1) && (s1_v == 0);
        br = (s2_bn == 0) && (s1_bn == 1);
        bf = (s2_bn == 1) && (s1_bn == 0);

        e_sof = (br && (vf || bf_cnt == 0)) ? 1 : 0;
        if (br) t_rise = t;
        if (s1_bn == 1) e_col = imin(t - t_rise, 1023);
        e_de = s1_bn;
        if (bf) begin
            vis_line = imin(t - t_rise, 1024);
            bf_cnt++;
        end

        bad_line = 0;
        if (hf) begin
            len = imin(t - t_hlast, 2047);
            t_hlast = t;
            e_line_len = len;
            bad_line = !(len == HT && (vis_line == 0 || vis_line == HA));
            if (bad_line) lines_good = 0;
            hf_cnt++;
            vis_line = 0;
        end

        bad_frame = 0;
        if (vf) begin
            e_frame_lines = imin(hf_cnt, 2047);
            good_frame = (frame_valid == 1) && (lines_good == 1) && hf_cnt == VT && bf_cnt == VA;
            bad_frame = !good_frame;
            hf_cnt = 0;
            bf_cnt = 0;
            frame_valid = 1;
            lines_good = 1;
        end

        was_locked = streak >= LF;
        e_err = (was_locked && (bad_line || bad_frame)) ? 1 : 0;
        if (bad_line || bad_frame) streak = 0;
        else if (vf) streak = imin(streak + 1, 100);
        e_locked = (streak >= LF) ? 1 : 0;
        e_row = imin(bf_cnt, 1023);

        s2_h = s1_h; s2_v = s1_v; s2_bn = s1_bn;
        s1_h = int'(h); s1_v = int'(v); s1_bn = int'(bn);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else if (clk) model_step();
        end
    end

    // One compare process: every output against the model, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("de",          int'(de),          e_de);
            check("col",         int'(col),         e_col);
            check("row",         int'(row),         e_row);
            check("sof",         int'(sof),         e_sof);
            check("locked",      int'(locked),      e_locked);
            check("err",         int'(err),         e_err);
            check("line_len",    int'(line_len),    e_line_len);
            check("frame_lines", int'(frame_lines), e_frame_lines);
        end
    end

    // Event monitor used by the literal checks.
    int err_seen = 0, err_line_len = 0, lock_rises = 0, prev_locked = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (err) begin
                err_seen++;
                err_line_len = int'(line_len);
            end
            if (locked && prev_locked == 0) lock_rises++;
            prev_locked = int'(locked);
        end
    end

    // ---------------- stimulus ----------------
    int frames_sent = 0;

    // chk bit0: literal coordinate checks; bit1: previous line was the long one
    task automatic send_line(input int len, input int act, input int r, input int chk);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            // outputs now reflect the pins driven two cycles earlier
            if ((chk & 1) != 0) begin
                if (r == 0 && c == 2) begin
                    check("first_px_de",  int'(de),  1);
                    check("first_px_col", int'(col), 0);
                    check("first_px_row", int'(row), 0);
                    check("first_px_sof", int'(sof), 1);
                end
                if (r == 0 && c == HA + 3) check("blank_de", int'(de), 0);
                if (r == VA - 1 && c == HA + 1) begin
                    check("last_px_de",  int'(de),  1);
                    check("last_px_col", int'(col), HA - 1);
                    check("last_px_row", int'(row), VA - 1);
                end
            end
            if ((chk & 2) != 0) begin
                if (c == 0) begin
                    check("long_col_sat", int'(col), 1023);
                    check("long_de_off",  int'(de),  0);
                end
                if (c == 2) begin
                    check("after_long_col", int'(col), 0);
                    check("after_long_de",  int'(de),  1);
                end
            end
            h  = !(c >= HS && c < HS + 4);
            v  = !(r == VS || r == VS + 1);
            bn = (r < VA) && (c < act);
        end
    endtask

    task automatic send_frame(input int nlines, input int stretch_row, input int stretch_len,
                              input int long_row, input int chk, input int rnd);
        int len, act, flags;
        for (int r = 0; r < nlines; r++) begin
            len = HT;
            act = HA;
            if (r == stretch_row) len = stretch_len;
            if (r == long_row) begin
                len = 1200;
                act = 1100;
            end
            if (rnd != 0) begin
                if ($urandom_range(0, 59) == 0) len = ($urandom_range(0, 1) == 0) ? HT - 1 : HT + 1;
                if ($urandom_range(0, 59) == 0) act = ($urandom_range(0, 1) == 0) ? HA - 1 : HA + 1;
            end
            flags = chk;
            if (long_row >= 0 && r == long_row + 1) flags = flags | 2;
            send_line(len, act, r, flags);
        end
        frames_sent++;
        $display("[TB] frame %0d: lines=%0d line_len=%0d frame_lines=%0d locked=%0d err_seen=%0d",
                 frames_sent, nlines, line_len, frame_lines, locked, err_seen);
    endtask

    task automatic nominal(input int n);
        for (int i = 0; i < n; i++) send_frame(VT, -1, 0, -1, 1, 0);
    endtask

    initial begin
        int e0, l0, nl;
        reset = 1'b0;
        h = 1'b1; v = 1'b1; bn = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        // Nominal lock acquisition: first frame ignored, locked after 3rd v fall
        nominal(2);
        check("lock_after_2_frames", int'(locked), 0);
        nominal(1);
        check("lock_after_3_frames", int'(locked), 1);
        check("nominal_line_len", int'(line_len), HT);
        check("nominal_frame_lines", int'(frame_lines), VT);
        check("nominal_no_err", err_seen, 0);

        // One stretched line while locked
        e0 = err_seen;
        send_frame(VT, 3, HT + 1, -1, 1, 0);
        check("stretch_err_count", err_seen - e0, 1);
        check("stretch_err_len", err_line_len, HT + 1);
        check("stretch_unlocked", int'(locked), 0);
        nominal(1);
        check("stretch_relock_1", int'(locked), 0);
        nominal(1);
        check("stretch_relock_2", int'(locked), 1);

        // Short frames never lock; restoring the count relocks
        l0 = lock_rises;
        for (int i = 0; i < 3; i++) send_frame(VT - 1, -1, 0, -1, 1, 0);
        check("short_frame_lines", int'(frame_lines), VT - 1);
        check("short_unlocked", int'(locked), 0);
        check("short_no_lock_rise", lock_rises - l0, 0);
        nominal(3);
        check("short_relock", int'(locked), 1);

        // bn held high for 1100 clocks
        send_frame(VT, -1, 0, 2, 1, 0);
        check("long_unlocked", int'(locked), 0);

        // Randomized perturbations checked by the model
        for (int i = 0; i < 24; i++) begin
            nl = VT;
            if ($urandom_range(0, 5) == 0) nl = ($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1;
            send_frame(nl, -1, 0, -1, 0, 1);
        end

        // Reset mid-frame while locked
        nominal(3);
        check("pre_reset_locked", int'(locked), 1);
        send_frame(5, -1, 0, -1, 0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_locked", int'(locked), 0);
        check("reset_line_len", int'(line_len), 0);
        check("reset_frame_lines", int'(frame_lines), 0);
        check("reset_row", int'(row), 0);
        h = 1'b1; v = 1'b1; bn = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        nominal(2);
        check("post_reset_lock_2", int'(locked), 0);
        nominal(1);
        check("post_reset_lock_3", int'(locked), 1);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
